axi_master_arbiter: RTL and testbench

AXI_MASTER_ARBITER -- requirements
Module: axi_master_arbiter

---
 rtl/axi_core_pkg.sv | 12 +
 rtl/rr_pick2.sv | 17 +
 rtl/axi_master_arbiter.sv | 141 ++++++++++++++
 tb/tb_axi_master_arbiter.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_core_pkg.sv
// Shared definitions for the AXI master arbiter: FSM encodings and default timeout.
package axi_core_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 255;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin winner selection; ptr names the requester that wins a tie.
module rr_pick2
   import axi_core_pkg::*;
(
   input  logic [1:0] req,
   input  logic       ptr,
   output logic [1:0] gnt
);

   always_comb begin
      gnt = req;
      if (req == 2'b11) begin
         gnt = ptr ? 2'b10 : 2'b01;
      end
   end

endmodule

// File: rtl/axi_master_arbiter.sv
// Arbitrates two requesters onto a single read/write master with round-robin
// fairness, a WAIT timeout and a one-cycle registered completion.
module axi_master_arbiter
   import axi_core_pkg::*;
#(
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
   input  logic                    aclk,
   input  logic                    aresetn,
   input  logic [1:0]              req,
   input  logic [1:0]              req_we,
   input  logic [2*ADDR_WIDTH-1:0] req_addr,
   input  logic [2*DATA_WIDTH-1:0] req_wdata,
   output logic [1:0]              ack,
   output logic                    err,
   output logic [DATA_WIDTH-1:0]   rdata,
   output logic [1:0]              grant,
   output logic                    m_start_write,
   output logic                    m_start_read,
   output logic [ADDR_WIDTH-1:0]   m_addr,
   output logic [DATA_WIDTH-1:0]   m_wdata,
   input  logic                    m_write_done,
   input  logic                    m_read_done,
   input  logic [DATA_WIDTH-1:0]   m_rdata,
   input  logic                    m_busy
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   state_t                state_q, state_d;
   logic                  ptr_q, ptr_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  we_q, we_d;
   logic [1:0]            ack_d, grant_d;
   logic                  err_d, start_w_d, start_r_d;
   logic [DATA_WIDTH-1:0] rdata_d, wdata_d;
   logic [ADDR_WIDTH-1:0] addr_d;
   logic [1:0]            pick_gnt;
   logic                  sel;
   logic                  done_ok;

   rr_pick2 u_pick (
      .req (req),
      .ptr (ptr_q),
      .gnt (pick_gnt)
   );

   assign sel     = pick_gnt[1];
   assign done_ok = we_q ? m_write_done : m_read_done;

   // Next-state and next-output logic
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      cnt_d     = cnt_q;
      we_d      = we_q;
      ack_d     = 2'b00;
      err_d     = 1'b0;
      rdata_d   = rdata;
      grant_d   = grant;
      start_w_d = 1'b0;
      start_r_d = 1'b0;
      addr_d    = m_addr;
      wdata_d   = m_wdata;

      case (state_q)
         ST_IDLE: begin
            if (!m_busy && (req != 2'b00)) begin
               addr_d    = sel ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr[ADDR_WIDTH-1:0];
               wdata_d   = sel ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : req_wdata[DATA_WIDTH-1:0];
               we_d      = req_we[sel];
               grant_d   = pick_gnt;
               start_w_d = req_we[sel];
               start_r_d = ~req_we[sel];
               cnt_d     = '0;
               state_d   = ST_WAIT;
            end
         end
         ST_WAIT: begin
            // A matching done wins over a timeout landing on the same edge
            if (done_ok) begin
               ack_d   = grant;
               rdata_d = we_q ? '0 : m_rdata;
               ptr_d   = grant[0];
               state_d = ST_RESP;
            end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               ack_d   = grant;
               err_d   = 1'b1;
               rdata_d = '0;
               ptr_d   = grant[0];
               state_d = ST_RESP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_RESP: begin
            grant_d = 2'b00;
            rdata_d = '0;
            state_d = ST_IDLE;
         end
         default: begin
            grant_d = 2'b00;
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q       <= ST_IDLE;
         ptr_q         <= 1'b0;
         cnt_q         <= '0;
         we_q          <= 1'b0;
         ack           <= 2'b00;
         err           <= 1'b0;
         rdata         <= '0;
         grant         <= 2'b00;
         m_start_write <= 1'b0;
         m_start_read  <= 1'b0;
         m_addr        <= '0;
         m_wdata       <= '0;
      end else begin
         state_q       <= state_d;
         ptr_q         <= ptr_d;
         cnt_q         <= cnt_d;
         we_q          <= we_d;
         ack           <= ack_d;
         err           <= err_d;
         rdata         <= rdata_d;
         grant         <= grant_d;
         m_start_write <= start_w_d;
         m_start_read  <= start_r_d;
         m_addr        <= addr_d;
         m_wdata       <= wdata_d;
      end
   end

endmodule

// File: tb/tb_axi_master_arbiter.sv
// Directed self-checking bench for axi_master_arbiter (TIMEOUT_CYCLES = 8).
module tb_axi_master_arbiter;

   localparam int unsigned DW = 32;
   localparam int unsigned AW = 32;

   logic          aclk;
   logic          aresetn;
   logic [1:0]    req;
   logic [1:0]    req_we;
   logic [2*AW-1:0] req_addr;
   logic [2*DW-1:0] req_wdata;
   logic [1:0]    ack;
   logic          err;
   logic [DW-1:0] rdata;
   logic [1:0]    grant;
   logic          m_start_write;
   logic          m_start_read;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata;
   logic          m_write_done;
   logic          m_read_done;
   logic [DW-1:0] m_rdata;
   logic          m_busy;

   int checks;
   int errors;

   axi_master_arbiter #(
      .DATA_WIDTH     (DW),
      .ADDR_WIDTH     (AW),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .aclk          (aclk),
      .aresetn       (aresetn),
      .req           (req),
      .req_we        (req_we),
      .req_addr      (req_addr),
      .req_wdata     (req_wdata),
      .ack           (ack),
      .err           (err),
      .rdata         (rdata),
      .grant         (grant),
      .m_start_write (m_start_write),
      .m_start_read  (m_start_read),
      .m_addr        (m_addr),
      .m_wdata       (m_wdata),
      .m_write_done  (m_write_done),
      .m_read_done   (m_read_done),
      .m_rdata       (m_rdata),
      .m_busy        (m_busy)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   // Advance one clock and settle just past the edge
   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic do_reset();
      aresetn = 1'b0;
      req = 2'b00;
      m_write_done = 1'b0;
      m_read_done = 1'b0;
      tick();
      tick();
      aresetn = 1'b1;
   endtask

   task automatic test_reset();
      aresetn = 1'b0;
      req = 2'b00; req_we = 2'b00; req_addr = '0; req_wdata = '0;
      m_write_done = 1'b0; m_read_done = 1'b0; m_rdata = '0; m_busy = 1'b0;
      tick();
      checks++;
      if ({ack, err, rdata, grant, m_start_write, m_start_read, m_addr, m_wdata} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got ack=%b err=%b rdata=%h grant=%b sw=%b sr=%b addr=%h wdata=%h exp all 0",
                  ack, err, rdata, grant, m_start_write, m_start_read, m_addr, m_wdata);
      end
      aresetn = 1'b1;
      tick();
      checks++;
      if (grant !== 2'b00) begin
         errors++;
         $display("FAIL reset_idle_grant got %b exp 00", grant);
      end
   endtask

   task automatic test_write();
      req = 2'b01; req_we = 2'b01;
      req_addr[AW-1:0] = 32'h10; req_wdata[DW-1:0] = 32'hA5A5A5A5;
      tick();
      checks++;
      if ({m_start_write, m_start_read, grant} !== 4'b1001) begin
         errors++;
         $display("FAIL wr_start got sw=%b sr=%b grant=%b exp sw=1 sr=0 grant=01", m_start_write, m_start_read, grant);
      end
      checks++;
      if (m_addr !== 32'h10 || m_wdata !== 32'hA5A5A5A5) begin
         errors++;
         $display("FAIL wr_capture got addr=%h wdata=%h exp 00000010 a5a5a5a5", m_addr, m_wdata);
      end
      req_addr[AW-1:0] = 32'hFF; req_wdata[DW-1:0] = 32'h0;
      tick();
      checks++;
      if (m_start_write !== 1'b0) begin
         errors++;
         $display("FAIL wr_pulse_width got %b exp 0", m_start_write);
      end
      tick();
      tick();
      checks++;
      if (ack !== 2'b00) begin
         errors++;
         $display("FAIL wr_early_ack got %b exp 00", ack);
      end
      m_write_done = 1'b1;
      tick();
      m_write_done = 1'b0;
      req = 2'b00;
      checks++;
      if (ack !== 2'b01 || err !== 1'b0 || rdata !== 32'h0) begin
         errors++;
         $display("FAIL wr_ack got ack=%b err=%b rdata=%h exp 01 0 00000000", ack, err, rdata);
      end
      checks++;
      if (m_addr !== 32'h10) begin
         errors++;
         $display("FAIL wr_addr_stable got %h exp 00000010", m_addr);
      end
      tick();
      checks++;
      if (ack !== 2'b00 || grant !== 2'b00) begin
         errors++;
         $display("FAIL wr_resp_exit got ack=%b grant=%b exp 00 00", ack, grant);
      end
   endtask

   task automatic test_read();
      req = 2'b10; req_we = 2'b00; req_addr[2*AW-1:AW] = 32'h20;
      tick();
      checks++;
      if ({m_start_read, m_start_write, grant, m_addr} !== {1'b1, 1'b0, 2'b10, 32'h20}) begin
         errors++;
         $display("FAIL rd_start got sr=%b sw=%b grant=%b addr=%h exp 1 0 10 00000020",
                  m_start_read, m_start_write, grant, m_addr);
      end
      tick();
      m_rdata = 32'hDEADBEEF; m_read_done = 1'b1;
      tick();
      m_read_done = 1'b0; m_rdata = '0; req = 2'b00;
      checks++;
      if (ack !== 2'b10 || err !== 1'b0 || rdata !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL rd_ack got ack=%b err=%b rdata=%h exp 10 0 deadbeef", ack, err, rdata);
      end
      tick();
   endtask

   task automatic test_contention();
      logic [1:0] exp_g [3];
      exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01;
      do_reset();
      req = 2'b11; req_we = 2'b11;
      req_addr = {32'h200, 32'h100};
      for (int k = 0; k < 3; k++) begin
         tick();
         checks++;
         if (grant !== exp_g[k] || m_start_write !== 1'b1) begin
            errors++;
            $display("FAIL cont_grant%0d got grant=%b sw=%b exp %b 1", k, grant, m_start_write, exp_g[k]);
         end
         m_write_done = 1'b1;
         tick();
         m_write_done = 1'b0;
         checks++;
         if (ack !== exp_g[k]) begin
            errors++;
            $display("FAIL cont_ack%0d got %b exp %b", k, ack, exp_g[k]);
         end
         tick();
         checks++;
         if (grant !== 2'b00) begin
            errors++;
            $display("FAIL cont_resp_regrant%0d got %b exp 00", k, grant);
         end
      end
      req = 2'b00;
      tick();
   endtask

   task automatic test_timeout();
      logic saw_ack;
      saw_ack = 1'b0;
      req = 2'b01; req_we = 2'b01; req_addr[AW-1:0] = 32'h30;
      m_rdata = 32'h12345678;
      tick();
      for (int i = 1; i < 8; i++) begin
         tick();
         if (ack !== 2'b00) saw_ack = 1'b1;
      end
      checks++;
      if (saw_ack !== 1'b0) begin
         errors++;
         $display("FAIL to_early_ack got 1 exp 0");
      end
      tick();
      req = 2'b00;
      checks++;
      if (ack !== 2'b01 || err !== 1'b1 || rdata !== 32'h0) begin
         errors++;
         $display("FAIL to_ack got ack=%b err=%b rdata=%h exp 01 1 00000000", ack, err, rdata);
      end
      tick();
      checks++;
      if (ack !== 2'b00 || err !== 1'b0) begin
         errors++;
         $display("FAIL to_clear got ack=%b err=%b exp 00 0", ack, err);
      end
      req = 2'b10; req_we = 2'b00;
      tick();
      m_rdata = 32'h5555AAAA; m_read_done = 1'b1;
      tick();
      m_read_done = 1'b0; req = 2'b00;
      checks++;
      if (ack !== 2'b10 || err !== 1'b0 || rdata !== 32'h5555AAAA) begin
         errors++;
         $display("FAIL to_next got ack=%b err=%b rdata=%h exp 10 0 5555aaaa", ack, err, rdata);
      end
      tick();
   endtask

   task automatic test_timeout_tie();
      req = 2'b01; req_we = 2'b01;
      tick();
      for (int i = 1; i < 8; i++) tick();
      m_write_done = 1'b1;
      tick();
      m_write_done = 1'b0; req = 2'b00;
      checks++;
      if (ack !== 2'b01 || err !== 1'b0) begin
         errors++;
         $display("FAIL tie_done_wins got ack=%b err=%b exp 01 0", ack, err);
      end
      tick();
   endtask

   task automatic test_wrong_done();
      req = 2'b01; req_we = 2'b01;
      tick();
      tick();
      m_read_done = 1'b1;
      tick();
      m_read_done = 1'b0;
      checks++;
      if (ack !== 2'b00) begin
         errors++;
         $display("FAIL wrong_done_ack got %b exp 00", ack);
      end
      tick();
      m_write_done = 1'b1;
      tick();
      m_write_done = 1'b0; req = 2'b00;
      checks++;
      if (ack !== 2'b01 || err !== 1'b0) begin
         errors++;
         $display("FAIL right_done_ack got ack=%b err=%b exp 01 0", ack, err);
      end
      tick();
   endtask

   task automatic test_busy();
      m_busy = 1'b1;
      req = 2'b01; req_we = 2'b00;
      tick();
      tick();
      checks++;
      if (grant !== 2'b00 || m_start_read !== 1'b0) begin
         errors++;
         $display("FAIL busy_hold got grant=%b sr=%b exp 00 0", grant, m_start_read);
      end
      m_busy = 1'b0;
      tick();
      checks++;
      if (grant !== 2'b01 || m_start_read !== 1'b1) begin
         errors++;
         $display("FAIL busy_release got grant=%b sr=%b exp 01 1", grant, m_start_read);
      end
      req = 2'b00;
      m_read_done = 1'b1;
      tick();
      m_read_done = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid();
      logic saw_ack;
      saw_ack = 1'b0;
      req = 2'b01; req_we = 2'b01;
      req_addr[AW-1:0] = 32'h44; req_wdata[DW-1:0] = 32'h99;
      tick();
      tick();
      aresetn = 1'b0;
      #1;
      checks++;
      if ({ack, err, rdata, grant, m_start_write, m_start_read, m_addr, m_wdata} !== '0) begin
         errors++;
         $display("FAIL midrst_outputs got ack=%b err=%b grant=%b addr=%h wdata=%h exp all 0",
                  ack, err, grant, m_addr, m_wdata);
      end
      req = 2'b00;
      m_write_done = 1'b1;
      tick();
      m_write_done = 1'b0;
      tick();
      aresetn = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (ack !== 2'b00) saw_ack = 1'b1;
      end
      checks++;
      if (saw_ack !== 1'b0) begin
         errors++;
         $display("FAIL midrst_stale_ack got 1 exp 0");
      end
      req = 2'b10; req_we = 2'b00; req_addr[2*AW-1:AW] = 32'h88;
      tick();
      checks++;
      if (grant !== 2'b10 || m_start_read !== 1'b1 || m_addr !== 32'h88) begin
         errors++;
         $display("FAIL midrst_regrant got grant=%b sr=%b addr=%h exp 10 1 00000088", grant, m_start_read, m_addr);
      end
      m_rdata = 32'hCAFE0001; m_read_done = 1'b1;
      tick();
      m_read_done = 1'b0; req = 2'b00;
      checks++;
      if (ack !== 2'b10 || rdata !== 32'hCAFE0001) begin
         errors++;
         $display("FAIL midrst_ack got ack=%b rdata=%h exp 10 cafe0001", ack, rdata);
      end
      tick();
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_write();
      test_read();
      test_contention();
      test_timeout();
      test_timeout_tie();
      test_wrong_done();
      test_busy();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
